// File: rtl/spi_pkg.sv
// spi_pkg -- shared types and default parameters for the SPI slave slice.
// The FSM state enum lives here so the top and any future blocks agree on it.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      FINISH = 2'd2
   } state_t;

   localparam int DEF_DATA_W     = 8;
   localparam int DEF_LSB_FIRST  = 1;
   localparam int DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/spi_rx_fifo.sv
// spi_rx_fifo -- synchronous receive FIFO clocked by sclk.
// A push into a full FIFO is accepted only when a pop happens on the same
// edge; otherwise the word is dropped and the caller decides what to flag.
module spi_rx_fifo #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          sclk,
   input  logic                          reset_n,
   input  logic                          push,
   input  logic [DATA_W-1:0]             push_data,
   input  logic                          pop,
   output logic [DATA_W-1:0]             head,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              push_ok;
   logic              pop_ok;

   assign full    = (count == DEPTH_C);
   assign empty   = (count == '0);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign head    = mem[rd_ptr];

   // Storage write on an accepted push.
   // NOTE: the storage array has no reset; count alone says which entries are valid.
   always_ff @(posedge sclk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
   always_ff @(posedge sclk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/spi_slave_fd.sv
// spi_slave_fd -- full-duplex SPI slave running entirely in the sclk domain.
// One shift register serves both directions: the TX word leaves from one end
// while MOSI enters at the other, so after DATA_W shifts it holds the RX word.
// Optional build macro: SPI_SLAVE_ERR_FLAGS_EN compiles in the sticky
// overrun/underrun flags and flag_clr; without it both flags read 0.
module spi_slave_fd
   import spi_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int LSB_FIRST  = DEF_LSB_FIRST,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic              sclk,
   input  logic              reset_n,
   input  logic              ss_n,
   input  logic              mosi,
   output logic              miso,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              done,
   output logic              overrun,
   output logic              underrun,
   input  logic              flag_clr
);

   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   state_t              state;
   state_t              next_state;
   logic [CNT_W-1:0]    bit_cnt;
   logic [DATA_W-1:0]   shreg;
   logic [DATA_W-1:0]   shifted;
   logic                out_bit;
   logic                load;
   logic                shift_en;
   logic                abort;
   logic                push;
   logic                fifo_full;
   logic                fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] fifo_count_unused;

   assign tx_ready = (state == IDLE);
   assign done     = (state == FINISH);
   assign rx_valid = !fifo_empty;

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge sclk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and datapath control decode.
   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      next_state = state;
      load       = 1'b0;
      shift_en   = 1'b0;
      abort      = 1'b0;
      push       = 1'b0;
      case (state)
         IDLE: begin
            if (!ss_n) begin
               load       = 1'b1;
               next_state = SHIFT;
            end
         end
         SHIFT: begin
            if (ss_n) begin
               abort      = 1'b1;
               next_state = IDLE;
            end else begin
               shift_en = 1'b1;
               if (bit_cnt == LAST_BIT) begin
                  push       = 1'b1;
                  next_state = FINISH;
               end
            end
         end
         FINISH: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Bit ordering: pick the outgoing bit and the register after one shift.
   always_comb begin
      out_bit = shreg[0];
      shifted = {mosi, shreg[DATA_W-1:1]};
      if (LSB_FIRST == 0) begin
         out_bit = shreg[DATA_W-1];
         shifted = {shreg[DATA_W-2:0], mosi};
      end
   end

   // Shift register, bit counter and registered MISO.
   always_ff @(posedge sclk or negedge reset_n) begin
      if (!reset_n) begin
         bit_cnt <= '0;
         shreg   <= '1;
         miso    <= 1'b1;
      end else if (load) begin
         bit_cnt <= '0;
         shreg   <= tx_valid ? tx_data : '1;
      end else if (shift_en) begin
         miso    <= out_bit;
         shreg   <= shifted;
         bit_cnt <= bit_cnt + 1'b1;
      end else if (abort) begin
         bit_cnt <= '0;
      end
   end

   spi_rx_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_rx_fifo (
      .sclk      (sclk),
      .reset_n   (reset_n),
      .push      (push),
      .push_data (shifted),
      .pop       (rx_ready),
      .head      (rx_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count_unused)
   );

`ifdef SPI_SLAVE_ERR_FLAGS_EN
   logic underrun_set;
   logic overrun_set;

   assign underrun_set = load && !tx_valid;
   assign overrun_set  = push && fifo_full && !(rx_ready && !fifo_empty);

   // Sticky error flags; a set on the same edge as flag_clr takes priority.
   always_ff @(posedge sclk or negedge reset_n) begin
      if (!reset_n) begin
         overrun  <= 1'b0;
         underrun <= 1'b0;
      end else begin
         if (overrun_set) begin
            overrun <= 1'b1;
         end else if (flag_clr) begin
            overrun <= 1'b0;
         end
         if (underrun_set) begin
            underrun <= 1'b1;
         end else if (flag_clr) begin
            underrun <= 1'b0;
         end
      end
   end
`else
   logic unused_err;

   assign overrun    = 1'b0;
   assign underrun   = 1'b0;
   assign unused_err = ^{flag_clr, fifo_full};
`endif

endmodule

// File: tb/tb_spi_slave_fd.sv
// tb_spi_slave_fd -- directed and randomized bench for spi_slave_fd.
// Two instances: u_lsb (LSB first, main model) and u_msb (MSB first).
// The reference keeps the RX FIFO as a queue and the sticky flags as bits.
`timescale 1ns/1ps
module tb_spi_slave_fd;

   localparam int DEPTH = 4;
`ifdef SPI_SLAVE_ERR_FLAGS_EN
   localparam bit FLAGS_EN = 1'b1;
`else
   localparam bit FLAGS_EN = 1'b0;
`endif

   logic       sclk = 1'b0;
   logic       reset_n;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       flag_clr;

   logic       ss_n_l, mosi_l, rx_ready_l;
   logic       miso_l, tx_ready_l, rx_valid_l, done_l, overrun_l, underrun_l;
   logic [7:0] rx_data_l;

   logic       ss_n_m, mosi_m, rx_ready_m;
   logic       miso_m, tx_ready_m, rx_valid_m, done_m, overrun_m, underrun_m;
   logic [7:0] rx_data_m;

   int         checks   = 0;
   int         failures = 0;

   logic [7:0] exp_q[$];
   logic       exp_ovr;
   logic       exp_udr;
   logic       exp_miso;

   always #5 sclk = ~sclk;

   spi_slave_fd #(.DATA_W(8), .LSB_FIRST(1), .FIFO_DEPTH(DEPTH)) u_lsb (
      .sclk(sclk), .reset_n(reset_n), .ss_n(ss_n_l), .mosi(mosi_l), .miso(miso_l),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready_l),
      .rx_data(rx_data_l), .rx_valid(rx_valid_l), .rx_ready(rx_ready_l),
      .done(done_l), .overrun(overrun_l), .underrun(underrun_l), .flag_clr(flag_clr)
   );

   spi_slave_fd #(.DATA_W(8), .LSB_FIRST(0), .FIFO_DEPTH(DEPTH)) u_msb (
      .sclk(sclk), .reset_n(reset_n), .ss_n(ss_n_m), .mosi(mosi_m), .miso(miso_m),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready_m),
      .rx_data(rx_data_m), .rx_valid(rx_valid_m), .rx_ready(rx_ready_m),
      .done(done_m), .overrun(overrun_m), .underrun(underrun_m), .flag_clr(flag_clr)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled on the falling edge.
   task automatic tick();
      @(posedge sclk);
      @(negedge sclk);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "/tx_ready"}, tx_ready_l, 1'b1);
      check({tag, "/done"}, done_l, 1'b0);
      check({tag, "/miso"}, miso_l, exp_miso);
      check({tag, "/overrun"}, overrun_l, exp_ovr);
      check({tag, "/underrun"}, underrun_l, exp_udr);
      check({tag, "/rx_valid"}, rx_valid_l, exp_q.size() != 0);
      if (exp_q.size() != 0) check({tag, "/rx_data"}, rx_data_l, exp_q[0]);
   endtask

   // Full or aborted frame on u_lsb. abort_at = shift index at which ss_n rises (8 = none).
   task automatic frame_l(input string tag, input logic [7:0] tx, input logic txv,
                          input logic [7:0] rxw, input int abort_at, input logic pop_on_push);
      logic [7:0] word;
      logic       pop;
      word     = txv ? tx : 8'hFF;
      pop      = 1'b0;
      tx_data  = tx;
      tx_valid = txv;
      ss_n_l   = 1'b0;
      tick();
      if (FLAGS_EN) begin
         if (!txv) exp_udr = 1'b1;
         else if (flag_clr) exp_udr = 1'b0;
         if (flag_clr) exp_ovr = 1'b0;
      end
      tx_valid = 1'b0;
      flag_clr = 1'b0;
      check({tag, "/start_ready"}, tx_ready_l, 1'b0);
      check({tag, "/start_underrun"}, underrun_l, exp_udr);
      check({tag, "/start_miso"}, miso_l, exp_miso);
      for (int k = 0; k < 8; k++) begin
         mosi_l = rxw[k];
         if (k == abort_at) begin
            ss_n_l = 1'b1;
            tick();
            check_idle({tag, "/abort"});
            return;
         end
         if (k == 7) begin
            rx_ready_l = pop_on_push;
            pop        = pop_on_push && (exp_q.size() != 0);
         end
         tick();
         exp_miso = word[k];
         check($sformatf("%s/miso%0d", tag, k), miso_l, exp_miso);
      end
      rx_ready_l = 1'b0;
      if (pop) exp_q.delete(0);
      if (exp_q.size() < DEPTH) exp_q.push_back(rxw);
      else if (FLAGS_EN) exp_ovr = 1'b1;
      check({tag, "/done"}, done_l, 1'b1);
      check({tag, "/finish_ready"}, tx_ready_l, 1'b0);
      check({tag, "/rx_valid"}, rx_valid_l, 1'b1);
      check({tag, "/rx_head"}, rx_data_l, exp_q[0]);
      check({tag, "/overrun"}, overrun_l, exp_ovr);
      ss_n_l = 1'b1;
      tick();
      check_idle({tag, "/end"});
   endtask

   task automatic pop_l(input string tag);
      check({tag, "/rx_valid"}, rx_valid_l, exp_q.size() != 0);
      if (exp_q.size() != 0) check({tag, "/rx_data"}, rx_data_l, exp_q[0]);
      rx_ready_l = 1'b1;
      tick();
      rx_ready_l = 1'b0;
      if (exp_q.size() != 0) exp_q.delete(0);
      check_idle({tag, "/after"});
   endtask

   task automatic clear_flags(input string tag);
      flag_clr = 1'b1;
      tick();
      flag_clr = 1'b0;
      exp_ovr  = 1'b0;
      exp_udr  = 1'b0;
      check_idle(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] txm;
      logic [7:0] rxm;

      reset_n    = 1'b0;
      tx_data    = 8'h00;
      tx_valid   = 1'b0;
      flag_clr   = 1'b0;
      ss_n_l     = 1'b1;
      mosi_l     = 1'b0;
      rx_ready_l = 1'b0;
      ss_n_m     = 1'b1;
      mosi_m     = 1'b0;
      rx_ready_m = 1'b0;
      exp_ovr    = 1'b0;
      exp_udr    = 1'b0;
      exp_miso   = 1'b1;

      // Reset state.
      @(negedge sclk);
      @(negedge sclk);
      check_idle("reset");
      check("reset/msb_miso", miso_m, 1'b1);
      check("reset/msb_rx_valid", rx_valid_m, 1'b0);
      reset_n = 1'b1;
      tick();

      // IDLE with ss_n high ignores tx_valid.
      tx_data  = 8'h5A;
      tx_valid = 1'b1;
      repeat (3) tick();
      tx_valid = 1'b0;
      check_idle("idle_hold");

      // Reference frame: tx 0xA5, rx 0x3C, LSB first.
      frame_l("basic", 8'hA5, 1'b1, 8'h3C, 8, 1'b0);
      pop_l("basic_pop");

      // MSB-first instance: tx 0x81, rx 0x42.
      txm      = 8'h81;
      rxm      = 8'h42;
      tx_data  = txm;
      tx_valid = 1'b1;
      ss_n_m   = 1'b0;
      tick();
      tx_valid = 1'b0;
      check("msb/start_ready", tx_ready_m, 1'b0);
      for (int k = 0; k < 8; k++) begin
         mosi_m = rxm[7-k];
         tick();
         check($sformatf("msb/miso%0d", k), miso_m, txm[7-k]);
      end
      check("msb/done", done_m, 1'b1);
      check("msb/rx_valid", rx_valid_m, 1'b1);
      check("msb/rx_data", rx_data_m, 8'h42);
      ss_n_m = 1'b1;
      tick();
      check("msb/done_low", done_m, 1'b0);
      check("msb/ready", tx_ready_m, 1'b1);
      rx_ready_m = 1'b1;
      tick();
      rx_ready_m = 1'b0;
      check("msb/popped", rx_valid_m, 1'b0);

      // Underrun: no TX word at frame start.
      frame_l("underrun", 8'h00, 1'b0, 8'h96, 8, 1'b0);
      clear_flags("underrun_clr");
      pop_l("underrun_pop");

      // Overrun: five frames without popping.
      for (int i = 0; i < 5; i++) begin
         a = 8'($urandom);
         b = 8'($urandom);
         frame_l($sformatf("fill%0d", i), a, 1'b1, b, 8, 1'b0);
      end
      check("overrun_set", overrun_l, FLAGS_EN);
      for (int i = 0; i < 4; i++) pop_l($sformatf("drain%0d", i));
      clear_flags("overrun_clr");

      // Full FIFO with a pop on the push edge: no overrun.
      for (int i = 0; i < 5; i++) begin
         a = 8'($urandom);
         b = 8'($urandom);
         frame_l($sformatf("popfill%0d", i), a, 1'b1, b, 8, i == 4);
      end
      check("no_overrun", overrun_l, 1'b0);
      for (int i = 0; i < 4; i++) pop_l($sformatf("popdrain%0d", i));

      // Abort after four shift edges, then a clean frame.
      frame_l("abort", 8'($urandom), 1'b1, 8'($urandom), 4, 1'b0);
      frame_l("post_abort", 8'h3E, 1'b1, 8'hC1, 8, 1'b0);
      pop_l("post_abort_pop");

      // Reset pulsed mid-frame after three bits.
      tx_data  = 8'($urandom);
      tx_valid = 1'b1;
      ss_n_l   = 1'b0;
      tick();
      tx_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         mosi_l = 1'($urandom);
         tick();
      end
      #2 reset_n = 1'b0;
      #1;
      exp_q.delete();
      exp_ovr  = 1'b0;
      exp_udr  = 1'b0;
      exp_miso = 1'b1;
      check_idle("mid_reset");
      ss_n_l = 1'b1;
      @(negedge sclk);
      reset_n = 1'b1;
      tick();
      check_idle("post_reset");
      frame_l("after_reset", 8'h6D, 1'b1, 8'h2B, 8, 1'b0);
      pop_l("after_reset_pop");

      // Set wins over a simultaneous clear.
      flag_clr = 1'b1;
      frame_l("set_wins", 8'h00, 1'b0, 8'h11, 8, 1'b0);
      clear_flags("set_wins_clr");

      // Randomized frames with random TX validity and pops.
      for (int i = 0; i < 12; i++) begin
         a = 8'($urandom);
         b = 8'($urandom);
         frame_l($sformatf("rand%0d", i), a, 1'($urandom_range(0, 3) != 0), b,
                 ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : 8,
                 1'($urandom));
      end
      while (exp_q.size() != 0) pop_l("final_drain");
      clear_flags("final_clr");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
